// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU opcode encoding and default latencies for the E-stage multiply/divide unit.
package mdu_ctrl_pkg;

   localparam logic [3:0] MDU_NONE  = 4'd0;
   localparam logic [3:0] MDU_MULT  = 4'd1;
   localparam logic [3:0] MDU_MULTU = 4'd2;
   localparam logic [3:0] MDU_DIV   = 4'd3;
   localparam logic [3:0] MDU_DIVU  = 4'd4;
   localparam logic [3:0] MDU_MFHI  = 4'd5;
   localparam logic [3:0] MDU_MFLO  = 4'd6;
   localparam logic [3:0] MDU_MTHI  = 4'd7;
   localparam logic [3:0] MDU_MTLO  = 4'd8;

   localparam int DEF_MULT_CYCLES = 5;
   localparam int DEF_DIV_CYCLES  = 10;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } mdu_state_t;

   function automatic logic is_md_start(input logic [3:0] op);
      return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

   function automatic logic is_div_op(input logic [3:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath producing {hi, lo} and a divide-by-zero flag.
module mdu_arith
   import mdu_ctrl_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   output logic [63:0] result,
   output logic        div_zero
);

   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;
   logic               signed_div;
   logic        [31:0] abs_rs;
   logic        [31:0] abs_rt;
   logic        [31:0] divisor;
   logic        [31:0] quo_mag;
   logic        [31:0] rem_mag;
   logic        [31:0] quo;
   logic        [31:0] rem;

   assign prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
   assign prod_u = {32'd0, rs} * {32'd0, rt};

   // Signed division works on magnitudes so that INT_MIN / -1 wraps to INT_MIN cleanly.
   always_comb begin
      signed_div = (op == MDU_DIV);
      abs_rs     = (signed_div && rs[31]) ? -rs : rs;
      abs_rt     = (signed_div && rt[31]) ? -rt : rt;
      divisor    = (rt == 32'd0) ? 32'd1 : abs_rt;
      quo_mag    = abs_rs / divisor;
      rem_mag    = abs_rs % divisor;
      quo        = (signed_div && (rs[31] ^ rt[31])) ? -quo_mag : quo_mag;
      rem        = (signed_div && rs[31]) ? -rem_mag : rem_mag;
   end

   always_comb begin
      result   = 64'd0;
      div_zero = 1'b0;
      case (op)
         MDU_MULT:  result = prod_s;
         MDU_MULTU: result = prod_u;
         MDU_DIV, MDU_DIVU: begin
            result   = {rem, quo};
            div_zero = (rt == 32'd0);
         end
         default: result = 64'd0;
      endcase
   end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage MDU sequencer: fixed-latency busy window, HI/LO ownership and D-stage stall request.
module mdu_ctrl
   import mdu_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  mdu_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        flush,
   input  logic        d_md_use,
   output logic        busy,
   output logic        start,
   output logic        stall_req,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] mdu_out
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   mdu_state_t       state;
   mdu_state_t       next_state;
   logic [CNT_W-1:0] counter;
   logic [31:0]      pend_hi;
   logic [31:0]      pend_lo;
   logic             pend_zero;
   logic [63:0]      arith_result;
   logic             arith_div_zero;

   mdu_arith u_arith (
      .op       (mdu_op),
      .rs       (rs_val),
      .rt       (rt_val),
      .result   (arith_result),
      .div_zero (arith_div_zero)
   );

   assign busy      = (state == RUN);
   assign start     = (state == IDLE) && !flush && is_md_start(mdu_op);
   assign stall_req = d_md_use && (start || busy);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = RUN;
         RUN:     if (counter == CNT_W'(1)) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // The result is captured at start so later operand changes in E cannot disturb it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         counter   <= '0;
         pend_hi   <= '0;
         pend_lo   <= '0;
         pend_zero <= 1'b0;
         hi        <= '0;
         lo        <= '0;
      end else if (start) begin
         pend_hi   <= arith_result[63:32];
         pend_lo   <= arith_result[31:0];
         pend_zero <= arith_div_zero;
         counter   <= is_div_op(mdu_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (busy) begin
         counter <= counter - CNT_W'(1);
         if (counter == CNT_W'(1) && !pend_zero) begin
            hi <= pend_hi;
            lo <= pend_lo;
         end
      end else if (!flush) begin
         if (mdu_op == MDU_MTHI) hi <= rs_val;
         if (mdu_op == MDU_MTLO) lo <= rs_val;
      end
   end

   always_comb begin
      mdu_out = 32'd0;
      case (mdu_op)
         MDU_MFHI: mdu_out = hi;
         MDU_MFLO: mdu_out = lo;
         default:  mdu_out = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: fixed vectors, corner-case sequences and randomized ops.
module tb_mdu_ctrl;
   import mdu_ctrl_pkg::*;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  mdu_op = MDU_NONE;
   logic [31:0] rs_val = '0;
   logic [31:0] rt_val = '0;
   logic        flush = 1'b0;
   logic        d_md_use = 1'b0;
   logic        busy;
   logic        start;
   logic        stall_req;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] mdu_out;

   int checks = 0;
   int errors = 0;
   logic [31:0] model_hi = '0;
   logic [31:0] model_lo = '0;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      logic        keep;
   } vec_t;

   vec_t vecs[7];

   mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk       (clk),
      .reset     (reset),
      .mdu_op    (mdu_op),
      .rs_val    (rs_val),
      .rt_val    (rt_val),
      .flush     (flush),
      .d_md_use  (d_md_use),
      .busy      (busy),
      .start     (start),
      .stall_req (stall_req),
      .hi        (hi),
      .lo        (lo),
      .mdu_out   (mdu_out)
   );

   always #5 clk = ~clk;

   // Reference arithmetic from the ISA definition using 64-bit integers.
   function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb, sq, sr;
      longint unsigned ua, ub;
      logic [63:0]     r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      r  = '0;
      case (op)
         MDU_MULT:  r = sa * sb;
         MDU_MULTU: r = ua * ub;
         MDU_DIV: begin
            sq = sa / sb;
            sr = sa % sb;
            r  = {sr[31:0], sq[31:0]};
         end
         MDU_DIVU: begin
            r = {32'(ua % ub), 32'(ua / ub)};
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic fl);
      mdu_op = op;
      rs_val = a;
      rt_val = b;
      flush  = fl;
      #1;
   endtask

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy === 1'b1 && n < 64) begin
         n++;
         tick();
      end
   endtask

   task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int n;
      int want_n;
      want_n = is_div_op(op) ? DIV_N : MULT_N;
      apply_stimulus(op, a, b, 1'b0);
      check_output({tag, "_start"}, 32'(start), 32'd1);
      tick();
      apply_stimulus(MDU_NONE, 32'd0, 32'd0, 1'b0);
      check_output({tag, "_hold_lo"}, lo, model_lo);
      wait_idle(n);
      check_output({tag, "_busy_len"}, 32'(n), 32'(want_n));
      model_hi = exp_hi;
      model_lo = exp_lo;
      check_output({tag, "_hi"}, hi, model_hi);
      check_output({tag, "_lo"}, lo, model_lo);
   endtask

   initial begin
      logic [63:0] r;
      logic [3:0]  op;
      logic [31:0] a, b;
      int          n;

      vecs[0] = '{MDU_MULT,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
      vecs[1] = '{MDU_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 1'b0};
      vecs[2] = '{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      vecs[3] = '{MDU_DIVU,  32'd7,        32'd0,        32'd0,        32'd0,        1'b1};
      vecs[4] = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
      vecs[5] = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
      vecs[6] = '{MDU_DIVU,  32'd7,        32'd3,        32'h00000001, 32'h00000002, 1'b0};

      #12;
      check_output("rst_busy", 32'(busy), 32'd0);
      check_output("rst_hi", hi, 32'd0);
      check_output("rst_lo", lo, 32'd0);
      reset = 1'b1;
      tick();

      for (int i = 0; i < 7; i++) begin
         if (vecs[i].keep) run_md($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt, model_hi, model_lo);
         else              run_md($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].exp_hi, vecs[i].exp_lo);
      end

      // Traffic during RUN: stall, ignored mt and md, mflo sees the old value.
      apply_stimulus(MDU_MULT, 32'd3, 32'd5, 1'b0);
      d_md_use = 1'b1;
      #1;
      check_output("stall_on_start", 32'(stall_req), 32'd1);
      tick();
      apply_stimulus(MDU_MTHI, 32'h1234, 32'd0, 1'b0);
      check_output("stall_in_run", 32'(stall_req), 32'd1);
      tick();
      check_output("mt_in_run_hi", hi, model_hi);
      apply_stimulus(MDU_MULT, 32'd7, 32'd7, 1'b0);
      check_output("no_restart_start", 32'(start), 32'd0);
      tick();
      apply_stimulus(MDU_MFLO, 32'd0, 32'd0, 1'b0);
      check_output("mflo_old", mdu_out, model_lo);
      d_md_use = 1'b0;
      tick();
      apply_stimulus(MDU_NONE, 32'd0, 32'd0, 1'b0);
      wait_idle(n);
      check_output("run_busy_len", 32'(3 + n), 32'(MULT_N));
      model_hi = 32'd0;
      model_lo = 32'd15;
      check_output("run_hi", hi, model_hi);
      check_output("run_lo", lo, model_lo);
      d_md_use = 1'b1;
      #1;
      check_output("stall_idle", 32'(stall_req), 32'd0);
      d_md_use = 1'b0;

      // Flush cancels both starts and mt writes.
      apply_stimulus(MDU_MULT, 32'd9, 32'd9, 1'b1);
      check_output("flush_start", 32'(start), 32'd0);
      tick();
      check_output("flush_busy", 32'(busy), 32'd0);
      check_output("flush_hi", hi, model_hi);
      apply_stimulus(MDU_MTLO, 32'hDEAD, 32'd0, 1'b1);
      tick();
      check_output("flush_mtlo", lo, model_lo);
      apply_stimulus(MDU_MTLO, 32'hBEEF, 32'd0, 1'b0);
      tick();
      model_lo = 32'hBEEF;
      check_output("mtlo", lo, model_lo);
      apply_stimulus(MDU_NONE, 32'd0, 32'd0, 1'b0);
      check_output("none_out", mdu_out, 32'd0);

      // Asynchronous reset in the middle of a divide.
      apply_stimulus(MDU_DIV, 32'd100, 32'd7, 1'b0);
      tick();
      apply_stimulus(MDU_NONE, 32'd0, 32'd0, 1'b0);
      tick();
      tick();
      tick();
      #2;
      reset = 1'b0;
      #1;
      check_output("arst_busy", 32'(busy), 32'd0);
      check_output("arst_hi", hi, 32'd0);
      check_output("arst_lo", lo, 32'd0);
      #1;
      reset = 1'b1;
      model_hi = '0;
      model_lo = '0;
      tick();
      apply_stimulus(MDU_MTHI, 32'hA5A5A5A5, 32'd0, 1'b0);
      tick();
      model_hi = 32'hA5A5A5A5;
      check_output("mthi_after_rst", hi, model_hi);

      // Randomized operations against the reference model.
      for (int i = 0; i < 30; i++) begin
         op = 4'($urandom_range(1, 4));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 9));
            2: a = 32'h80000000;
            default: ;
         endcase
         if ($urandom_range(0, 4) == 0) begin
            op = ($urandom_range(0, 1) == 1) ? MDU_MTHI : MDU_MTLO;
            apply_stimulus(op, a, 32'd0, 1'b0);
            tick();
            if (op == MDU_MTHI) model_hi = a;
            else                model_lo = a;
         end else if (is_div_op(op) && b == 32'd0) begin
            run_md($sformatf("rnd%0d", i), op, a, b, model_hi, model_lo);
         end else begin
            r = ref_result(op, a, b);
            run_md($sformatf("rnd%0d", i), op, a, b, r[63:32], r[31:0]);
         end
         apply_stimulus(MDU_MFHI, 32'd0, 32'd0, 1'b0);
         check_output($sformatf("rnd%0d_mfhi", i), mdu_out, model_hi);
         apply_stimulus(MDU_MFLO, 32'd0, 32'd0, 1'b0);
         check_output($sformatf("rnd%0d_mflo", i), mdu_out, model_lo);
      end

      apply_stimulus(MDU_NONE, 32'd0, 32'd0, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
mdu_ctrl sequences the multiply/divide unit in the E stage of the pipelined MIPS core. It accepts a decoded MDU operation with its operands and runs a fixed-latency busy window. It owns the HI/LO registers and drives the stall request that holds MDU-dependent instructions in D. Exception flush suppresses new starts and register writes.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
mdu_op  in  4  E-stage MDU operation code (MDU_* constants)
rs_val  in  32  forwarded rs operand
rt_val  in  32  forwarded rt operand
flush  in  1  exception/eret cancels the E-stage instruction this cycle
d_md_use  in  1  D-stage instruction is md, mt or mf
busy  out  1  operation in progress
start  out  1  combinational: mult/multu/div/divu accepted this cycle
stall_req  out  1  combinational: d_md_use & (start | busy)
hi  out  32  HI register
lo  out  32  LO register
mdu_out  out  32  combinational: hi on mfhi, lo on mflo, else 0

Behaviour:
- Reset (reset=0, async): state=IDLE, counter=0, hi=lo=0, pending regs=0, busy=0.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- start = (state==IDLE) & ~flush & mdu_op in {mult, multu, div, divu}.
- On a start edge:
  - Compute the result into pend_hi/pend_lo.
  - counter = MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
- In RUN, each edge decrements counter. On the edge where counter==1: hi/lo <= pend, go to IDLE.
- Latency: start at edge k -> busy=1 for cycles k+1..k+N; new hi/lo visible after edge k+N.
- Arithmetic:
  - mult: signed 32x32 -> 64; hi=[63:32], lo=[31:0].
  - multu: same as mult, unsigned.
  - div: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - divu: unsigned div.
  - 0x80000000 div 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divisor 0 (div/divu): full DIV_CYCLES busy window, but no commit; hi/lo retained.
- mthi/mtlo: in IDLE with ~flush, hi or lo <= rs_val at the edge; no busy.
- mthi/mtlo while busy: ignored. stall_req normally prevents this case.
- md op arriving in RUN: ignored, no restart. stall_req normally prevents this case.
- mfhi/mflo: pure read of the current hi/lo. No state change, legal in any state.
- flush: gates start and mt writes in the same cycle. An operation already in RUN always runs to completion and commits.
- Simultaneous commit and an mt op on the same edge: state is RUN, so the mt is ignored.
- Reset mid-operation: immediate abort; all registers cleared.
- MDU_none or unknown code: no effect.

Decomposition:
- MDU_* opcodes live in defines.v, shared with the decoder:
  - none=0, mult=1, multu=2, div=3, divu=4, mfhi=5, mflo=6, mthi=7, mtlo=8.
- The same file also holds the default MULT_CYCLES/DIV_CYCLES values.
- One natural sub-module: mdu_arith. It is purely combinational: op, rs, rt -> 64-bit {hi, lo} plus a div_zero flag. mdu_ctrl keeps the state machine, counter and registers.

Test Plan:
1. mult rs=0xFFFFFFFF rt=2 -> start=1 one cycle; busy=1 exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
2. multu rs=0xFFFFFFFF rt=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE; hi/lo unchanged during busy.
3. div rs=0xFFFFFFF9 (-7) rt=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then divu 7/0 -> busy 10 cycles, hi/lo unchanged.
4. While busy, d_md_use=1 -> stall_req=1. mthi rs=0x1234 and a second mult during RUN -> ignored. mflo returns the old lo until commit.
5. mult with flush=1 in the same cycle -> start=0, busy stays 0, hi/lo unchanged. mtlo with flush=1 -> lo unchanged.
6. div started, reset=0 asserted mid-cycle at busy cycle 4 -> busy=0, hi=lo=0 immediately (no clock needed). After release, mthi 0xA5A5A5A5 -> hi=0xA5A5A5A5 next edge.
